// File: rtl/arch_state_dumper.sv
// Debug snapshot streamer: on a trigger, halts the CPU and emits PC, register file and
// data memory as one framed valid/ready word sequence.
module arch_state_dumper #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned PERIOD    = 16,
  parameter int unsigned IDX_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              retire_i,
  input  logic [DATA_W-1:0] pc_match_i,
  input  logic              trig_i,
  output logic              halt_o,
  output logic [IDX_W-1:0]  reg_raddr_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic [IDX_W-1:0]  mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [1:0]        dump_tag_o,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic              dump_last_o,
  output logic [15:0]       frame_cnt_o,
  output logic              overrun_o
);

  typedef enum logic [1:0] {StIdle, StHdr, StReg, StMem} state_e;

  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(PERIOD - 1);
  localparam logic [IDX_W-1:0] RegLast = IDX_W'(NREG - 1);
  localparam logic [IDX_W-1:0] MemLast = IDX_W'(MEM_WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] hdr_pc_q, hdr_pc_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              overrun_q, overrun_d;
  logic [CntW-1:0]   retire_cnt_q, retire_cnt_d;

  logic trig_cond;
  logic xfer;
  logic last_word;

  always_comb begin
    case (trig_mode_i)
      2'd1:    trig_cond = retire_i && (retire_cnt_q == CntLast);
      2'd2:    trig_cond = retire_i && (pc_i == pc_match_i);
      2'd3:    trig_cond = trig_i;
      default: trig_cond = 1'b0;
    endcase
  end

  assign xfer      = (state_q != StIdle) && dump_ready_i;
  assign last_word = (state_q == StMem) && (idx_q == MemLast);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hdr_pc_d     = hdr_pc_q;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = overrun_q;
    retire_cnt_d = retire_cnt_q;
    case (state_q)
      StIdle: begin
        if (trig_mode_i == 2'd1 && retire_i) begin
          retire_cnt_d = (retire_cnt_q == CntLast) ? '0 : retire_cnt_q + CntW'(1);
        end
        if (trig_cond) begin
          state_d  = StHdr;
          hdr_pc_d = pc_i;
          idx_d    = '0;
        end
      end
      StHdr: begin
        if (xfer) begin
          state_d = StReg;
          idx_d   = '0;
        end
      end
      StReg: begin
        if (xfer) begin
          if (idx_q == RegLast) begin
            state_d = StMem;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StMem: begin
        if (xfer) begin
          if (last_word) begin
            state_d      = StIdle;
            idx_d        = '0;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            retire_cnt_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Triggers seen while a frame is in flight (including on the last word) are dropped.
    if (state_q != StIdle && trig_cond) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      hdr_pc_q     <= '0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hdr_pc_q     <= hdr_pc_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Read data passes straight through; the halted CPU and held address keep it stable.
  always_comb begin
    dump_data_o = '0;
    dump_tag_o  = 2'd0;
    dump_idx_o  = '0;
    reg_raddr_o = '0;
    mem_raddr_o = '0;
    case (state_q)
      StHdr: dump_data_o = hdr_pc_q;
      StReg: begin
        reg_raddr_o = idx_q;
        dump_data_o = reg_rdata_i;
        dump_tag_o  = 2'd1;
        dump_idx_o  = idx_q;
      end
      StMem: begin
        mem_raddr_o = idx_q;
        dump_data_o = mem_rdata_i;
        dump_tag_o  = 2'd2;
        dump_idx_o  = idx_q;
      end
      default: ;
    endcase
  end

  assign halt_o       = (state_q != StIdle);
  assign dump_valid_o = (state_q != StIdle);
  assign dump_last_o  = last_word;
  assign frame_cnt_o  = frame_cnt_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_arch_state_dumper.sv
// Directed bench for arch_state_dumper: reset, frame contents, backpressure, all trigger modes,
// overrun and mid-frame reset.
module tb_arch_state_dumper;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  trig_mode_i;
  logic [31:0] pc_i;
  logic        retire_i;
  logic [31:0] pc_match_i;
  logic        trig_i;
  logic        halt_o;
  logic [7:0]  reg_raddr_o;
  logic [31:0] reg_rdata_i;
  logic [7:0]  mem_raddr_o;
  logic [31:0] mem_rdata_i;
  logic        dump_valid_o;
  logic        dump_ready_i;
  logic [31:0] dump_data_o;
  logic [1:0]  dump_tag_o;
  logic [7:0]  dump_idx_o;
  logic        dump_last_o;
  logic [15:0] frame_cnt_o;
  logic        overrun_o;

  int checks = 0;
  int failures = 0;
  int exp_fc = 0;

  always #5 clk_i = ~clk_i;

  // Register file and memory contents are a fixed function of the address.
  assign reg_rdata_i = {24'hA0_0000, reg_raddr_o};
  assign mem_rdata_i = {24'hB0_0000, mem_raddr_o};

  arch_state_dumper #(
    .DATA_W(32), .NREG(32), .MEM_WORDS(32), .PERIOD(4), .IDX_W(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trig_mode_i(trig_mode_i), .pc_i(pc_i),
    .retire_i(retire_i), .pc_match_i(pc_match_i), .trig_i(trig_i), .halt_o(halt_o),
    .reg_raddr_o(reg_raddr_o), .reg_rdata_i(reg_rdata_i), .mem_raddr_o(mem_raddr_o),
    .mem_rdata_i(mem_rdata_i), .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_data_o(dump_data_o), .dump_tag_o(dump_tag_o), .dump_idx_o(dump_idx_o),
    .dump_last_o(dump_last_o), .frame_cnt_o(frame_cnt_o), .overrun_o(overrun_o)
  );

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // Expected word k of a 65-word frame with header value hdr.
  function automatic void exp_word(input int k, input logic [31:0] hdr, output logic [31:0] d,
                                   output logic [1:0] t, output logic [7:0] i, output logic l);
    if (k == 0) begin
      d = hdr; t = 2'd0; i = 8'd0; l = 1'b0;
    end else if (k <= 32) begin
      i = 8'(k - 1); t = 2'd1; d = 32'hA000_0000 | 32'(k - 1); l = 1'b0;
    end else begin
      i = 8'(k - 33); t = 2'd2; d = 32'hB000_0000 | 32'(k - 33); l = (k == 64);
    end
  endfunction

  task automatic test_reset;
    rst_i = 1'b1;
    step;
    step;
    checks++;
    if (halt_o !== 1'b0 || dump_valid_o !== 1'b0 || dump_last_o !== 1'b0 ||
        overrun_o !== 1'b0 || frame_cnt_o !== 16'd0 || reg_raddr_o !== 8'd0 ||
        mem_raddr_o !== 8'd0 || dump_idx_o !== 8'd0) begin
      failures++;
      $display("FAIL reset_state got halt=%b v=%b last=%b ovr=%b fc=%0d ra=%0d ma=%0d idx=%0d exp all 0",
               halt_o, dump_valid_o, dump_last_o, overrun_o, frame_cnt_o, reg_raddr_o,
               mem_raddr_o, dump_idx_o);
    end
    rst_i = 1'b0;
    step;
  endtask

  task automatic test_mode3;
    logic [31:0] ed; logic [1:0] et; logic [7:0] ei; logic el;
    trig_mode_i = 2'd3; pc_i = 32'h40; trig_i = 1'b1;
    step;
    trig_i = 1'b0;
    for (int k = 0; k < 65; k++) begin
      exp_word(k, 32'h40, ed, et, ei, el);
      checks++;
      if (dump_valid_o !== 1'b1 || halt_o !== 1'b1 || dump_data_o !== ed ||
          dump_tag_o !== et || dump_idx_o !== ei || dump_last_o !== el) begin
        failures++;
        $display("FAIL mode3_word k=%0d got v=%b h=%b d=%h t=%0d i=%0d l=%b exp d=%h t=%0d i=%0d l=%b",
                 k, dump_valid_o, halt_o, dump_data_o, dump_tag_o, dump_idx_o, dump_last_o,
                 ed, et, ei, el);
      end
      step;
    end
    exp_fc++;
    checks++;
    if (halt_o !== 1'b0 || dump_valid_o !== 1'b0 || frame_cnt_o !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL mode3_end got halt=%b v=%b fc=%0d exp halt=0 v=0 fc=%0d",
               halt_o, dump_valid_o, frame_cnt_o, exp_fc);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ed; logic [1:0] et; logic [7:0] ei; logic el;
    int k = 0;
    int stall = 0;
    int cyc = 0;
    trig_mode_i = 2'd3; pc_i = 32'h1234; trig_i = 1'b1;
    step;
    trig_i = 1'b0;
    while (k < 65 && cyc < 200) begin
      exp_word(k, 32'h1234, ed, et, ei, el);
      checks++;
      if (dump_valid_o !== 1'b1 || dump_data_o !== ed || dump_tag_o !== et ||
          dump_idx_o !== ei || dump_last_o !== el) begin
        failures++;
        $display("FAIL bp_word k=%0d cyc=%0d got v=%b d=%h t=%0d i=%0d l=%b exp d=%h t=%0d i=%0d l=%b",
                 k, cyc, dump_valid_o, dump_data_o, dump_tag_o, dump_idx_o, dump_last_o,
                 ed, et, ei, el);
      end
      dump_ready_i = !(k == 6 && stall < 4);
      if (!dump_ready_i) stall++;
      step;
      if (dump_ready_i) k++;
      cyc++;
    end
    dump_ready_i = 1'b1;
    exp_fc++;
    checks++;
    if (k != 65 || stall != 4 || cyc != 69 || halt_o !== 1'b0 || frame_cnt_o !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL bp_end got words=%0d stall=%0d cyc=%0d halt=%b fc=%0d exp 65 4 69 0 %0d",
               k, stall, cyc, halt_o, frame_cnt_o, exp_fc);
    end
  endtask

  task automatic test_reset_mid_frame;
    int n = 0;
    trig_mode_i = 2'd3; pc_i = 32'h77; trig_i = 1'b1;
    step;
    trig_i = 1'b0;
    repeat (10) step;
    rst_i = 1'b1;
    step;
    checks++;
    if (halt_o !== 1'b0 || dump_valid_o !== 1'b0 || dump_last_o !== 1'b0 ||
        frame_cnt_o !== 16'd0 || overrun_o !== 1'b0 || dump_data_o !== 32'd0 ||
        dump_idx_o !== 8'd0 || dump_tag_o !== 2'd0 || reg_raddr_o !== 8'd0) begin
      failures++;
      $display("FAIL midrst_state got halt=%b v=%b l=%b fc=%0d ovr=%b d=%h i=%0d t=%0d ra=%0d exp all 0",
               halt_o, dump_valid_o, dump_last_o, frame_cnt_o, overrun_o, dump_data_o,
               dump_idx_o, dump_tag_o, reg_raddr_o);
    end
    rst_i = 1'b0;
    exp_fc = 0;
    step;
    trig_i = 1'b1;
    step;
    trig_i = 1'b0;
    checks++;
    if (dump_data_o !== 32'h77 || dump_tag_o !== 2'd0) begin
      failures++;
      $display("FAIL midrst_hdr got d=%h t=%0d exp d=00000077 t=0", dump_data_o, dump_tag_o);
    end
    while (halt_o && n < 100) begin
      n++;
      step;
    end
    exp_fc++;
    checks++;
    if (n != 65 || frame_cnt_o !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL midrst_refr got halt_cycles=%0d fc=%0d exp 65 %0d", n, frame_cnt_o, exp_fc);
    end
  endtask

  task automatic test_mode1;
    int nret = 0;
    int nhalt = 0;
    int frames = 0;
    trig_mode_i = 2'd1; pc_i = 32'h100;
    for (int cyc = 0; cyc < 400 && frames < 2; cyc++) begin
      retire_i = !halt_o;
      step;
      if (retire_i) nret++;
      if (halt_o) begin
        nhalt++;
        if (nhalt == 1) begin
          checks++;
          if (dump_data_o !== 32'h100 || dump_tag_o !== 2'd0) begin
            failures++;
            $display("FAIL mode1_hdr got d=%h t=%0d exp d=00000100 t=0", dump_data_o, dump_tag_o);
          end
        end
      end else if (nhalt != 0) begin
        checks++;
        if (nret != 4 || nhalt != 65) begin
          failures++;
          $display("FAIL mode1_period frame=%0d got retires=%0d halt_cycles=%0d exp 4 65",
                   frames, nret, nhalt);
        end
        frames++;
        nret = 0;
        nhalt = 0;
      end
    end
    retire_i = 1'b0;
    trig_mode_i = 2'd0;
    exp_fc += 2;
    checks++;
    if (frames != 2 || frame_cnt_o !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL mode1_frames got frames=%0d fc=%0d exp 2 %0d", frames, frame_cnt_o, exp_fc);
    end
  endtask

  task automatic test_mode2;
    int n;
    trig_mode_i = 2'd2; pc_match_i = 32'h1C;
    for (int it = 0; it < 3; it++) begin
      for (int j = 0; j < 5; j++) begin
        pc_i = 32'h10 + 32'(4 * j);
        retire_i = 1'b1;
        step;
        retire_i = 1'b0;
        checks++;
        if (j == 3) begin
          if (halt_o !== 1'b1 || dump_data_o !== 32'h1C || dump_tag_o !== 2'd0) begin
            failures++;
            $display("FAIL mode2_hdr it=%0d got halt=%b d=%h t=%0d exp halt=1 d=0000001c t=0",
                     it, halt_o, dump_data_o, dump_tag_o);
          end
          n = 0;
          while (halt_o && n < 100) begin
            n++;
            step;
          end
          exp_fc++;
          checks++;
          if (n != 65 || frame_cnt_o !== 16'(exp_fc)) begin
            failures++;
            $display("FAIL mode2_frame it=%0d got halt_cycles=%0d fc=%0d exp 65 %0d",
                     it, n, frame_cnt_o, exp_fc);
          end
        end else if (halt_o !== 1'b0) begin
          failures++;
          $display("FAIL mode2_nomatch it=%0d pc=%h got halt=%b exp 0", it, pc_i, halt_o);
        end
      end
    end
    trig_mode_i = 2'd0;
  endtask

  task automatic test_overrun;
    int n = 0;
    int seen = 0;
    trig_mode_i = 2'd3; pc_i = 32'h55; trig_i = 1'b1;
    step;
    trig_i = 1'b0;
    repeat (5) step;
    trig_i = 1'b1;
    step;
    trig_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b1 || halt_o !== 1'b1 || dump_tag_o !== 2'd1 || dump_idx_o !== 8'd5) begin
      failures++;
      $display("FAIL ovr_set got ovr=%b halt=%b t=%0d i=%0d exp 1 1 1 5",
               overrun_o, halt_o, dump_tag_o, dump_idx_o);
    end
    trig_mode_i = 2'd0;
    while (halt_o && n < 100) begin
      n++;
      step;
    end
    trig_mode_i = 2'd3;
    exp_fc++;
    checks++;
    if (n != 59 || frame_cnt_o !== 16'(exp_fc) || overrun_o !== 1'b1) begin
      failures++;
      $display("FAIL ovr_frame got remaining=%0d fc=%0d ovr=%b exp 59 %0d 1",
               n, frame_cnt_o, overrun_o, exp_fc);
    end
    repeat (10) begin
      step;
      if (halt_o) seen++;
    end
    checks++;
    if (seen != 0 || overrun_o !== 1'b1 || frame_cnt_o !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL ovr_noextra got halt_cycles=%0d ovr=%b fc=%0d exp 0 1 %0d",
               seen, overrun_o, frame_cnt_o, exp_fc);
    end
  endtask

  task automatic test_back_to_back;
    int seen = 0;
    rst_i = 1'b1;
    step;
    rst_i = 1'b0;
    exp_fc = 0;
    trig_mode_i = 2'd3; pc_i = 32'h99; trig_i = 1'b1;
    step;
    trig_i = 1'b0;
    repeat (64) step;
    checks++;
    if (dump_last_o !== 1'b1 || dump_idx_o !== 8'd31 || overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_last got l=%b i=%0d ovr=%b exp 1 31 0", dump_last_o, dump_idx_o, overrun_o);
    end
    trig_i = 1'b1;
    step;
    trig_i = 1'b0;
    exp_fc++;
    checks++;
    if (halt_o !== 1'b0 || overrun_o !== 1'b1 || frame_cnt_o !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL b2b_drop got halt=%b ovr=%b fc=%0d exp 0 1 %0d",
               halt_o, overrun_o, frame_cnt_o, exp_fc);
    end
    repeat (5) begin
      step;
      if (halt_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL b2b_noframe got halt_cycles=%0d exp 0", seen);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    trig_mode_i = 2'd0;
    pc_i = 32'd0;
    retire_i = 1'b0;
    pc_match_i = 32'd0;
    trig_i = 1'b0;
    dump_ready_i = 1'b1;
    test_reset;
    test_mode3;
    test_backpressure;
    test_reset_mid_frame;
    test_mode1;
    test_mode2;
    test_overrun;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
